// File: rtl/common_types_pkg.sv
// Shared AHB-Lite encodings and the SRAM subordinate state type.
// Latency: none (declarations only).
// Backpressure: n/a.
package common_types_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} ahb_sub_state_t;

  // Little-endian byte lanes touched by a transfer; sizes above word act as word.
  function automatic logic [3:0] ahb_byte_lanes(input logic [1:0] addr_lo,
                                                input logic [2:0] size);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/sram_1r1w.sv
// Synchronous word array: one registered read port, one byte-enabled write port.
// Latency: read data appears one cycle after re and holds until the next re.
// Backpressure: none; a same-address read and write on one edge returns the old word.
module sram_1r1w #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register: captures the addressed word and holds it between reads.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word SRAM; optional ERROR responses under AHB_SRAM_ERROR_EN.
// Latency: data phase is WAIT_STATES+1 cycles; an errored transfer takes exactly two cycles.
// Backpressure: hreadyout low during wait/ERR1 cycles; new address phases accepted only while hreadyout=1.
module ahb_sram_subordinate
  import common_types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS_RELOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  ahb_sub_state_t state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;

  logic           accept, xfer_err, rd_go, commit;
  logic [AW-1:0]  acc_idx;
  logic [3:0]     acc_lanes;

  logic           wr_pend_q;
  logic [AW-1:0]  wr_idx_q;
  logic [3:0]     wr_lanes_q;

  logic [3:0]     fwd_lanes_q;
  logic [31:0]    fwd_dat_q;
  logic [31:0]    fwd_mask;
  logic [31:0]    sram_rdata;

  // hburst and the upper address bits carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0], haddr[31:AW+2]};

`ifdef AHB_SRAM_ERROR_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  assign hreadyout = (state_q == IDLE) || (state_q == ERR2);
  assign hresp     = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign xfer_err  = (haddr >= ADDR_LIMIT) ||
                     (hsize > HSIZE_WORD) ||
                     ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`else
  assign hreadyout = (state_q != WAIT);
  assign hresp     = HRESP_OKAY;
  assign xfer_err  = 1'b0;
`endif

  // Gating with our own hreadyout keeps a stray mux hready from restarting a live data phase.
  assign accept    = hsel && htrans[1] && hready && hreadyout;
  assign acc_idx   = haddr[AW+1:2];
  assign acc_lanes = ahb_byte_lanes(haddr[1:0], hsize);
  assign rd_go     = accept && !hwrite && !xfer_err;
  // A pending write only exists outside the ERR states, so hreadyout marks its final cycle.
  assign commit    = wr_pend_q && hreadyout && !rst;

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
`ifdef AHB_SRAM_ERROR_EN
      ERR1: state_d = ERR2;
`endif
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_d = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_RELOAD;
          end
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending write: captured at accept, retired when its data phase completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend_q  <= 1'b0;
      wr_idx_q   <= '0;
      wr_lanes_q <= 4'b0;
    end else if (accept) begin
      wr_pend_q  <= hwrite && !xfer_err;
      wr_idx_q   <= acc_idx;
      wr_lanes_q <= acc_lanes;
    end else if (commit) begin
      wr_pend_q  <= 1'b0;
    end
  end

  // Forwarding capture: lanes committed to the word being read on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_lanes_q <= 4'b0;
      fwd_dat_q   <= '0;
    end else if (rd_go) begin
      fwd_lanes_q <= (commit && (wr_idx_q == acc_idx)) ? wr_lanes_q : 4'b0;
      fwd_dat_q   <= hwdata;
    end
  end

  // Merge forwarded lanes over the word read from the array.
  always_comb begin
    fwd_mask = '0;
    for (int b = 0; b < 4; b++) fwd_mask[8*b +: 8] = {8{fwd_lanes_q[b]}};
  end

  assign hrdata = (fwd_dat_q & fwd_mask) | (sram_rdata & ~fwd_mask);

  sram_1r1w #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .rst   (rst),
    .re    (rd_go),
    .raddr (acc_idx),
    .rdata (sram_rdata),
    .we    (commit),
    .waddr (wr_idx_q),
    .wbe   (wr_lanes_q),
    .wdata (hwdata)
  );

endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

AHB-Lite subordinate fronting an on-chip word-organised SRAM; it is the responder end of the bus driven by the core's AHB-Lite manager. Sits behind the bus mux on one HSEL output and serves instruction fetches and data loads/stores, with configurable wait states and byte/halfword/word writes. Provides OKAY responses, plus two-cycle ERROR responses when compiled in.

## Interface
- DEPTH_WORDS, 1024: SRAM depth in 32-bit words; power of two.
- WAIT_STATES, 1: wait cycles inserted per data phase, range 0..7.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- hsel  in  1  subordinate select from address decoder
- haddr  in  32  byte address (address phase)
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  000 byte, 001 halfword, 010 word
- hburst  in  3  ignored; each beat handled as a single transfer
- hwdata  in  32  write data (data phase)
- hready  in  1  bus-level HREADY from the mux
- hreadyout  out  1  this subordinate's ready
- hresp  out  1  0 OKAY, 1 ERROR
- hrdata  out  32  read data, valid when hreadyout=1 ending a read data phase

## Operation
- Accept: hsel & htrans[1] & hready on a rising edge latches haddr, hwrite, hsize and byte lanes. BUSY/IDLE or unselected: no access; the following data phase is zero-wait OKAY.
- Byte lanes, little-endian: byte → lane haddr[1:0]; halfword → lanes {haddr[1],0}+{0,1}; word → all four.
- States: IDLE (hreadyout=1, hresp=0), WAIT (hreadyout=0, counter counts down), ERR1 (hreadyout=0, hresp=1), ERR2 (hreadyout=1, hresp=1).
- On accept of a valid transfer: WAIT_STATES>0 → WAIT with counter=WAIT_STATES-1, else stays IDLE. WAIT → IDLE when counter=0. ERR2 → IDLE, or straight into the next accepted transfer.
- Read: array read on the accept edge; result held in a read register until that data phase completes.
- Write: array written on the edge that completes the data phase (hreadyout=1), using hwdata masked by the latched lanes.
- Forwarding: if a read is accepted on the same edge a write commits to the same word, hrdata returns the newly written lanes merged over the old word.
- Address index = haddr[$clog2(DEPTH_WORDS)+1:2].
- Reset: hreadyout=1, hresp=0, hrdata=0, state IDLE, counter 0, pending write dropped (no commit). SRAM contents are not reset.

## Timing
- Data phase lasts WAIT_STATES+1 cycles: hreadyout low for WAIT_STATES cycles, then high for one.
- WAIT_STATES=0 gives back-to-back transfers at one per cycle.
- A new address phase can be accepted only on the edge where hready=1, i.e. when the previous data phase completes.
- ERROR takes exactly two cycles (ERR1, ERR2) and no wait states precede it. The errored transfer performs no write, and hrdata holds its previous value.
- Reset asserted mid-WAIT: the next cycle shows hreadyout=1 and no write occurs.

## Configuration
- AHB_SRAM_ERROR_EN defined: each of these gets the ERR1/ERR2 response with no array access:
  - out-of-range address (haddr ≥ 4*DEPTH_WORDS),
  - misaligned halfword or word,
  - hsize > 010.
- Undefined: always OKAY; address wraps modulo the depth, misaligned addresses are aligned down, and hsize > 010 is treated as a word. ERR states are not synthesised.

## Structure
- Shared package common_types_pkg:
  - existing HTRANS_* constants,
  - new HSIZE_BYTE/HALF/WORD constants,
  - typedef ahb_sub_state_t {IDLE, WAIT, ERR1, ERR2},
  - HRESP_OKAY/HRESP_ERROR.
- Sub-module sram_1r1w: synchronous 1-read/1-write word array with 4-bit byte-write enable, parameterised by depth. The forwarding mux lives in the parent.

## Test plan
- WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 → hreadyout low for 1 cycle, then hrdata=0xDEADBEEF, hresp=0.
- Byte write 0xAA to 0x13 over 0x11223344 → read 0x10 returns 0xAA223344; halfword write 0x5566 to 0x10 → 0xAA225566.
- WAIT_STATES=0: write 0x12345678 to 0x20, then immediately read 0x20 back-to-back → forwarded 0x12345678 with no stall.
- AHB_SRAM_ERROR_EN: word read at 0x2 → ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE; array unchanged.
- htrans=BUSY or hsel=0 → hreadyout=1, hresp=0, no array write.
- rst during WAIT of a write to 0x30 → hreadyout=1 next cycle; a later read of 0x30 returns the old value.
